// File: rtl/emu_reset_seq_pkg.sv
// Shared types and helpers for the emulated-domain reset sequencer.
// Pure declarations: no logic, no latency.
// No flow control; imported by the sequencer top and its tick counter.
package emu_reset_seq_pkg;

   // Sequencer phases: all domains held, staggered releases, normal running.
   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_GAP  = 2'd1,
      ST_RUN  = 2'd2
   } seq_state_t;

   // Width needed to count up to the longer of the two durations, never below 1.
   function automatic int cnt_width(input int hold_cycles, input int gap_cycles);
      int longest;
      int w;
      longest = (hold_cycles > gap_cycles) ? hold_cycles : gap_cycles;
      w       = $clog2(longest + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/emu_tick_counter.sv
// Tick-gated up-counter that wraps to zero on reaching a programmable terminal value.
// done is combinational on the tick edge that hits terminal; cnt updates one edge later.
// No backpressure: advances only when tick is 1; clear wins over counting.
module emu_tick_counter
   import emu_reset_seq_pkg::*;
#(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         tick,
   input  logic         clear,
   input  logic [W-1:0] terminal,
   output logic [W-1:0] cnt,
   output logic         done
);

   // Terminal count is reached on this tick edge.
   assign done = tick && (cnt == terminal);

   // Count model time steps; restart from zero after the terminal step or on clear.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cnt <= '0;
      end else if (clear || done) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/emu_reset_sequencer.sv
// Sequences active-high resets of emulated domains: hold all, then release in index order.
// Hold/gap durations are counted in tick steps; all outputs registered (one edge after decision).
// req_valid/req_ready restart handshake is only offered in RUN; requests elsewhere are ignored.
module emu_reset_sequencer
   import emu_reset_seq_pkg::*;
#(
   parameter int NUM_DOMAINS = 4,
   parameter int HOLD_CYCLES = 20,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   tick,
   input  logic                   req_valid,
   output logic                   req_ready,
   output logic                   busy,
   output logic [NUM_DOMAINS-1:0] domain_reset,
   output logic                   all_released
);

   localparam int CNT_W       = cnt_width(HOLD_CYCLES, GAP_CYCLES);
   localparam int IDX_W       = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam int HOLD_TERM_I = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;
   localparam int GAP_TERM_I  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] HOLD_TERM = HOLD_TERM_I[CNT_W-1:0];
   localparam logic [CNT_W-1:0] GAP_TERM  = GAP_TERM_I[CNT_W-1:0];
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DOMAINS - 1);

   if (NUM_DOMAINS < 1) begin : g_bad_domains
      $error("emu_reset_sequencer: NUM_DOMAINS must be at least 1");
   end

   seq_state_t             state_q;
   seq_state_t             state_d;
   logic [IDX_W-1:0]       idx_q;
   logic [IDX_W-1:0]       idx_d;
   logic [NUM_DOMAINS-1:0] rst_d;
   logic [CNT_W-1:0]       terminal;
   logic [CNT_W-1:0]       cnt_unused;
   logic                   cnt_done;
   logic                   cnt_clear;
   logic                   hold_done;
   logic                   handshake;

   // The counter value itself is only of interest when probing the design.
   emu_tick_counter #(
      .W (CNT_W)
   ) u_tick_counter (
      .clk      (clk),
      .resetn   (resetn),
      .tick     (tick),
      .clear    (cnt_clear),
      .terminal (terminal),
      .cnt      (cnt_unused),
      .done     (cnt_done)
   );

   // A zero-length hold releases domain 0 on the first edge, tick or not.
   assign hold_done = (HOLD_CYCLES == 0) ? 1'b1 : cnt_done;
   assign handshake = req_valid && req_ready;
   assign terminal  = (state_q == ST_GAP) ? GAP_TERM : HOLD_TERM;

   // Next state, release index and next domain_reset image; defaults hold everything.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rst_d     = domain_reset;
      case (state_q)
         ST_HOLD: begin
            if (hold_done) begin
               if (GAP_CYCLES == 0 || NUM_DOMAINS == 1) begin
                  // No stagger needed: everything comes out of reset together.
                  rst_d   = '0;
                  idx_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  rst_d[0] = 1'b0;
                  idx_d    = IDX_W'(1);
                  state_d  = ST_GAP;
               end
            end
         end
         ST_GAP: begin
            if (cnt_done) begin
               for (int i = 0; i < NUM_DOMAINS; i++) begin
                  if (i == int'(idx_q)) begin
                     rst_d[i] = 1'b0;
                  end
               end
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = ST_RUN;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         ST_RUN: begin
            rst_d = '0;
            if (handshake) begin
               rst_d   = '1;
               idx_d   = '0;
               state_d = ST_HOLD;
            end
         end
         default: begin
            rst_d   = '1;
            idx_d   = '0;
            state_d = ST_HOLD;
         end
      endcase
      // Each phase starts its count from zero; RUN keeps the counter parked.
      cnt_clear = (state_q == ST_RUN) || (state_d != state_q);
   end

   // State register and registered outputs derived from the next state.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= ST_HOLD;
         idx_q        <= '0;
         domain_reset <= '1;
         busy         <= 1'b1;
         req_ready    <= 1'b0;
         all_released <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         domain_reset <= rst_d;
         busy         <= (state_d != ST_RUN);
         req_ready    <= (state_d == ST_RUN);
         all_released <= (state_d == ST_RUN);
      end
   end

endmodule

// File: tb/tb_emu_reset_sequencer.sv
// Directed bench for emu_reset_sequencer across three parameter sets.
// Outputs are sampled 1 time unit after each rising edge.
// Expected values come from hand tables and a small release-time formula.
module tb_emu_reset_sequencer;

   logic       clk;
   logic       resetn;
   logic       tick;
   logic       req_valid;

   logic       a_ready, a_busy, a_rel;
   logic [2:0] a_rst;
   logic       b_ready, b_busy, b_rel;
   logic [3:0] b_rst;
   logic       c_ready, c_busy, c_rel;
   logic [0:0] c_rst;

   int total;
   int bad;

   // Main configuration: three domains, hold 5, gap 2.
   emu_reset_sequencer #(.NUM_DOMAINS(3), .HOLD_CYCLES(5), .GAP_CYCLES(2)) u_a (
      .clk(clk), .resetn(resetn), .tick(tick), .req_valid(req_valid),
      .req_ready(a_ready), .busy(a_busy), .domain_reset(a_rst), .all_released(a_rel));

   // Zero-duration configuration.
   emu_reset_sequencer #(.NUM_DOMAINS(4), .HOLD_CYCLES(0), .GAP_CYCLES(0)) u_b (
      .clk(clk), .resetn(resetn), .tick(tick), .req_valid(req_valid),
      .req_ready(b_ready), .busy(b_busy), .domain_reset(b_rst), .all_released(b_rel));

   // Single-domain configuration.
   emu_reset_sequencer #(.NUM_DOMAINS(1), .HOLD_CYCLES(3), .GAP_CYCLES(7)) u_c (
      .clk(clk), .resetn(resetn), .tick(tick), .req_valid(req_valid),
      .req_ready(c_ready), .busy(c_busy), .domain_reset(c_rst), .all_released(c_rel));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       tick;
      logic [2:0] a_rst;
      logic       a_busy;
      logic       a_rel;
      logic       c_rst;
   } vec_t;

   vec_t vecs[11];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Expected u_a reset image after n ticks counted from the first released edge.
   function automatic logic [2:0] exp_a(input int n);
      if (n < 5)      return 3'b111;
      else if (n < 7) return 3'b110;
      else if (n < 9) return 3'b100;
      else            return 3'b000;
   endfunction

   task automatic check_a(input string name, input int n);
      check({name, ".rst"},   {29'd0, a_rst},   {29'd0, exp_a(n)});
      check({name, ".busy"},  {31'd0, a_busy},  {31'd0, (n < 9)});
      check({name, ".ready"}, {31'd0, a_ready}, {31'd0, (n >= 9)});
      check({name, ".rel"},   {31'd0, a_rel},   {31'd0, (n >= 9)});
   endtask

   initial begin
      int ticks;
      total = 0;
      bad   = 0;

      //               tick  a_rst   busy  rel   c_rst
      vecs[0]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 3'b111, 1'b1, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 3'b110, 1'b1, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, 3'b100, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 3'b000, 1'b0, 1'b1, 1'b0};

      resetn    = 1'b0;
      tick      = 1'b1;
      req_valid = 1'b0;
      step();
      step();

      // Reset state of every instance.
      check("rst.a_rst",   {29'd0, a_rst},   32'h7);
      check("rst.a_busy",  {31'd0, a_busy},  32'h1);
      check("rst.a_ready", {31'd0, a_ready}, 32'h0);
      check("rst.a_rel",   {31'd0, a_rel},   32'h0);
      check("rst.b_rst",   {28'd0, b_rst},   32'hf);
      check("rst.b_rel",   {31'd0, b_rel},   32'h0);
      check("rst.c_rst",   {31'd0, c_rst},   32'h1);
      check("rst.c_busy",  {31'd0, c_busy},  32'h1);

      // Scenario 1 and single-domain scenario, tick always high.
      resetn = 1'b1;
      for (int e = 0; e < 11; e++) begin
         tick = vecs[e].tick;
         step();
         check($sformatf("s1.e%0d.a_rst", e + 1),  {29'd0, a_rst},   {29'd0, vecs[e].a_rst});
         check($sformatf("s1.e%0d.a_busy", e + 1), {31'd0, a_busy},  {31'd0, vecs[e].a_busy});
         check($sformatf("s1.e%0d.a_rel", e + 1),  {31'd0, a_rel},   {31'd0, vecs[e].a_rel});
         check($sformatf("s1.e%0d.a_rdy", e + 1),  {31'd0, a_ready}, {31'd0, vecs[e].a_rel});
         check($sformatf("s1.e%0d.c_rst", e + 1),  {31'd0, c_rst},   {31'd0, vecs[e].c_rst});
         check($sformatf("s1.e%0d.c_rel", e + 1),  {31'd0, c_rel},   {31'd0, ~vecs[e].c_rst});
      end

      // Scenario 3: one-cycle restart request in RUN, then a held request while busy.
      req_valid = 1'b1;
      step();
      check("s3.hs.a_rst",  {29'd0, a_rst},   32'h7);
      check("s3.hs.a_busy", {31'd0, a_busy},  32'h1);
      check("s3.hs.a_rdy",  {31'd0, a_ready}, 32'h0);
      for (int n = 1; n <= 10; n++) begin
         req_valid = (n <= 8);
         step();
         check_a($sformatf("s3.e%0d", n), n);
      end
      req_valid = 1'b0;

      // Scenario 2: tick high on every second edge only.
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      ticks  = 0;
      for (int e = 1; e <= 20; e++) begin
         tick = (e % 2 == 0);
         if (tick) ticks++;
         step();
         check_a($sformatf("s2.e%0d", e), ticks);
      end
      tick = 1'b1;

      // Scenario 5: reset pulse mid-sequence restarts the timing from scratch.
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int e = 1; e <= 7; e++) step();
      check("s5.pre.a_rst", {29'd0, a_rst}, 32'h4);
      resetn = 1'b0;
      step();
      check("s5.rst.a_rst",  {29'd0, a_rst},  32'h7);
      check("s5.rst.a_busy", {31'd0, a_busy}, 32'h1);
      resetn = 1'b1;
      for (int n = 1; n <= 9; n++) begin
         step();
         check_a($sformatf("s5.e%0d", n), n);
      end

      // Scenario 4: zero hold and gap release everything on the first edge without tick.
      resetn = 1'b0;
      tick   = 1'b0;
      step();
      check("s4.rst.b_rst", {28'd0, b_rst}, 32'hf);
      resetn = 1'b1;
      step();
      check("s4.e1.b_rst",  {28'd0, b_rst},   32'h0);
      check("s4.e1.b_rel",  {31'd0, b_rel},   32'h1);
      check("s4.e1.b_busy", {31'd0, b_busy},  32'h0);
      check("s4.e1.b_rdy",  {31'd0, b_ready}, 32'h1);
      check("s4.e1.a_rst",  {29'd0, a_rst},   32'h7);
      step();
      check("s4.e2.a_rst",  {29'd0, a_rst},   32'h7);
      check("s4.e2.c_rst",  {31'd0, c_rst},   32'h1);
      check("s4.e2.c_busy", {31'd0, c_busy},  32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/emu_reset_sequencer.md
Name: emu_reset_sequencer

Overview:
- Synthesizable controller that sequences the resets of several emulated sub-design domains.
- Holds all domains in reset for a programmed number of emulated time steps, then releases them one by one in index order, with a fixed gap between releases.
- Runs only on `tick` cycles, i.e. model time steps, so pausing the emulator freezes the sequence.
- Accepts a valid/ready request to re-run the full sequence once the design is running.

Parameters:
- NUM_DOMAINS, 4, number of reset domains (>=1; elaboration error otherwise).
- HOLD_CYCLES, 20, ticks all domains stay in reset before domain 0 is released (0 allowed).
- GAP_CYCLES, 4, ticks between release of domain i and domain i+1 (0 allowed).

Ports:
- clk  input  1  single clock.
- resetn  input  1  synchronous, active-low reset.
- tick  input  1  emulated time-step enable; counters and tick-driven transitions advance only when 1.
- req_valid  input  1  request to re-run the reset sequence.
- req_ready  output  1  request accepted when req_valid && req_ready at a clk edge.
- busy  output  1  sequence in progress.
- domain_reset  output  NUM_DOMAINS  bit i = active-high reset of domain i.
- all_released  output  1  every domain out of reset.

Behaviour:
- Reset (resetn=0 sampled at clk edge): state=HOLD, cnt=0, idx=0, domain_reset=all ones, busy=1, req_ready=0, all_released=0. Reset mid-sequence or in RUN restarts from this state.
- All outputs are registered. busy=(state!=RUN), req_ready=all_released=(state==RUN).
- Counter width: localparam CNT_W = clog2(max(HOLD_CYCLES,GAP_CYCLES)+1), minimum 1.
- HOLD state:
  - On each tick edge cnt++.
  - On the tick edge where cnt==HOLD_CYCLES-1: clear domain_reset[0], cnt=0, idx=1, go to GAP. If NUM_DOMAINS==1, go to RUN instead.
  - HOLD_CYCLES==0: the first edge after reset performs the domain-0 release regardless of tick.
- GAP state:
  - On each tick edge cnt++.
  - On the tick edge where cnt==GAP_CYCLES-1: clear domain_reset[idx], cnt=0, idx++.
  - If the released idx was NUM_DOMAINS-1, go to RUN.
- GAP_CYCLES==0: at the end of HOLD, all domains clear on the same edge and the state goes directly to RUN.
- RUN state:
  - domain_reset=0.
  - On a handshake (req_valid && req_ready): next edge sets domain_reset=all ones, cnt=0, idx=0, state=HOLD.
  - The handshake does not need tick.
- req_valid outside RUN: ignored, not queued. The requester must hold it until accepted.
- tick=0 in HOLD/GAP: state, cnt and domain_reset hold their values, except for the zero-parameter cases above.
- Release order is strictly ascending index. No domain ever re-asserts reset except through resetn or an accepted request.
- Release latency with tick always 1: domain i deasserts HOLD_CYCLES + i*GAP_CYCLES edges after the first edge with resetn=1, the first edge counted as 1. all_released asserts on the same edge as the last domain release.

Decomposition:
- Package emu_reset_seq_pkg: state enum typedef {HOLD, GAP, RUN} (2-bit encoding), and a function computing CNT_W from the two duration parameters.
- One natural sub-module, emu_tick_counter:
  - Inputs: tick, clear, terminal value.
  - Outputs: cnt and a `done` pulse on the terminal tick edge.
  - Shared by the HOLD and GAP states.
- The FSM and the domain_reset register stay in the top module.

Test Plan:
1. NUM_DOMAINS=3, HOLD=5, GAP=2, tick=1 constant, resetn released before edge 1 -> domain_reset=111 through edge 4, 110 after edge 5, 100 after edge 7, 000 after edge 9, all_released=req_ready=1 and busy=0 after edge 9.
2. Same config, tick high only on every 2nd cycle -> each release lands at 2x the edge count of scenario 1 (110 after edge 10, 000 after edge 18); no change on tick=0 edges.
3. In RUN, pulse req_valid for one cycle -> domain_reset=111 and busy=1 next edge; the sequence repeats with scenario-1 timing. req_valid held during HOLD/GAP produces no restart and no handshake.
4. HOLD=0, GAP=0, NUM_DOMAINS=4, tick=0 -> domain_reset=1111 during reset, 0000 and all_released=1 after first edge with resetn=1.
5. Assert resetn=0 for one cycle while domain_reset=100 in scenario 1 -> next edge domain_reset=111, cnt=0; release timing restarts from scratch.
6. NUM_DOMAINS=1, HOLD=3, GAP=7 -> domain_reset=0 and RUN after edge 3; GAP never entered.
